stop_watch_ctrl: RTL and testbench

//  Control FSM for the 4-digit BCD stopwatch datapath (M.SS.T digits d3..d0).

---
 rtl/stop_watch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Control FSM for a 4-digit BCD stopwatch: turns start/stop, lap and clear buttons into
// datapath go/clr/up controls, freezes the display on lap and raises an alarm when a countdown reaches 0.00.0.
module stop_watch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DIGIT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_go,
    input  logic               btn_lap,
    input  logic               btn_clr,
    input  logic               sw_up,
    input  logic [DIGIT_W-1:0] cnt_d3,
    input  logic [DIGIT_W-1:0] cnt_d2,
    input  logic [DIGIT_W-1:0] cnt_d1,
    input  logic [DIGIT_W-1:0] cnt_d0,
    output logic               go,
    output logic               clr,
    output logic               up,
    output logic [DIGIT_W-1:0] disp_d3,
    output logic [DIGIT_W-1:0] disp_d2,
    output logic [DIGIT_W-1:0] disp_d1,
    output logic [DIGIT_W-1:0] disp_d0,
    output logic               alarm,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    // Button bit order inside the vectors: [2]=clr, [1]=lap, [0]=go
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] synced, dly_q, press;

    logic [DIGIT_W-1:0] lap_d3, lap_d2, lap_d1, lap_d0;
    logic prev_zero, zero, running, zero_hit;
    logic up_next, clr_next, lap_load;
    logic ev_go, ev_lap, ev_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q[0] <= {btn_clr, btn_lap, btn_go};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= synced;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign press  = synced & ~dly_q;
    assign ev_go  = press[0];
    assign ev_lap = press[1];
    assign ev_clr = press[2];

    assign zero     = (cnt_d3 == '0) && (cnt_d2 == '0) && (cnt_d1 == '0) && (cnt_d0 == '0);
    assign running  = (state == S_RUN) || (state == S_LAP);
    // Only a fresh arrival at zero counts, so a countdown started at 0.00.0 wraps instead of firing
    assign zero_hit = running && !up && zero && !prev_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the highest-priority press (clr > go > lap) is acted on; a dominant but ignored clr masks the rest
    always_comb begin
        state_next = state;
        up_next    = up;
        clr_next   = 1'b0;
        lap_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ev_clr) begin
                    clr_next = 1'b1;
                end else if (ev_go) begin
                    state_next = S_RUN;
                    up_next    = sw_up;
                end
            end
            S_RUN: begin
                if (zero_hit) begin
                    state_next = S_DONE;
                end else if (!ev_clr) begin
                    if (ev_go) begin
                        state_next = S_PAUSE;
                    end else if (ev_lap) begin
                        state_next = S_LAP;
                        lap_load   = 1'b1;
                    end
                end
            end
            S_LAP: begin
                if (zero_hit) begin
                    state_next = S_DONE;
                end else if (!ev_clr) begin
                    if (ev_go) begin
                        state_next = S_PAUSE;
                    end else if (ev_lap) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_next = S_IDLE;
                    clr_next   = 1'b1;
                end else if (ev_go) begin
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (ev_clr) begin
                    state_next = S_IDLE;
                    clr_next   = 1'b1;
                end else if (ev_go) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up        <= 1'b1;
            clr       <= 1'b1;
            prev_zero <= 1'b1;
            lap_d3    <= '0;
            lap_d2    <= '0;
            lap_d1    <= '0;
            lap_d0    <= '0;
        end else begin
            up        <= up_next;
            clr       <= clr_next;
            prev_zero <= zero;
            if (lap_load) begin
                lap_d3 <= cnt_d3;
                lap_d2 <= cnt_d2;
                lap_d1 <= cnt_d1;
                lap_d0 <= cnt_d0;
            end
        end
    end

    assign go        = running;
    assign alarm     = (state == S_DONE);
    assign disp_d3   = (state == S_LAP) ? lap_d3 : cnt_d3;
    assign disp_d2   = (state == S_LAP) ? lap_d2 : cnt_d2;
    assign disp_d1   = (state == S_LAP) ? lap_d1 : cnt_d1;
    assign disp_d0   = (state == S_LAP) ? lap_d0 : cnt_d0;
    assign dbg_state = state;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl: a tenths-of-second datapath model feeds the digits, and a
// mode-level reference model built from the button/press rules predicts every output.
module tb_stop_watch_ctrl;

    localparam int SYNC = 2;
    localparam int M_IDLE = 10, M_RUN = 20, M_LAP = 30, M_PAUSE = 40, M_DONE = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_go = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0, sw_up = 1'b1;
    logic [3:0] cnt_d3, cnt_d2, cnt_d1, cnt_d0;
    logic go, clr, up, alarm;
    logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0;
    logic [2:0] dbg_state;
    logic [15:0] disp_all;

    int checks = 0;
    int failures = 0;

    // Datapath stand-in: count held as tenths of a second, 0..5999 (9.59.9)
    int cnt_val = 0;
    bit preset_req = 1'b0;
    int preset_val = 0;

    // Reference model
    int m_mode = M_IDLE;
    bit m_up = 1'b1, m_clr = 1'b1, m_prev_zero = 1'b1;
    int m_lap = 0;
    bit h_go[0:SYNC], h_lap[0:SYNC], h_clr[0:SYNC];
    int n_mode, n_lap;
    bit n_up, n_clr, e_go, e_lap, e_clr, m_hit, m_running;

    stop_watch_ctrl #(.SYNC_STAGES(SYNC), .DIGIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .btn_go(btn_go), .btn_lap(btn_lap), .btn_clr(btn_clr), .sw_up(sw_up),
        .cnt_d3(cnt_d3), .cnt_d2(cnt_d2), .cnt_d1(cnt_d1), .cnt_d0(cnt_d0),
        .go(go), .clr(clr), .up(up),
        .disp_d3(disp_d3), .disp_d2(disp_d2), .disp_d1(disp_d1), .disp_d0(disp_d0),
        .alarm(alarm), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits(input int v);
        return {4'(v / 600), 4'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_disp();
        return (m_mode == M_LAP) ? digits(m_lap) : digits(cnt_val);
    endfunction

    assign {cnt_d3, cnt_d2, cnt_d1, cnt_d0} = digits(cnt_val);
    assign disp_all = {disp_d3, disp_d2, disp_d1, disp_d0};

    // A press is seen SYNC edges after the first high sample, once per rising edge of the button
    always_comb begin
        e_go      = h_go[SYNC-1] && !h_go[SYNC];
        e_lap     = h_lap[SYNC-1] && !h_lap[SYNC];
        e_clr     = h_clr[SYNC-1] && !h_clr[SYNC];
        m_running = (m_mode == M_RUN) || (m_mode == M_LAP);
        m_hit     = m_running && !m_up && (cnt_val == 0) && !m_prev_zero;
        n_mode    = m_mode;
        n_up      = m_up;
        n_clr     = 1'b0;
        n_lap     = m_lap;
        if (m_hit) begin
            n_mode = M_DONE;
        end else if (e_clr) begin
            if (!m_running) begin
                n_mode = M_IDLE;
                n_clr  = 1'b1;
            end
        end else if (e_go) begin
            if (m_mode == M_IDLE) begin
                n_mode = M_RUN;
                n_up   = sw_up;
            end else if (m_running) begin
                n_mode = M_PAUSE;
            end else if (m_mode == M_PAUSE) begin
                n_mode = M_RUN;
            end else begin
                n_mode = M_IDLE;
            end
        end else if (e_lap) begin
            if (m_mode == M_RUN) begin
                n_mode = M_LAP;
                n_lap  = cnt_val;
            end else if (m_mode == M_LAP) begin
                n_mode = M_RUN;
            end
        end
    end

    always @(posedge clk) begin
        if (preset_req) cnt_val <= preset_val;
        else if (m_clr) cnt_val <= 0;
        else if (m_running) cnt_val <= m_up ? (cnt_val + 1) % 6000 : (cnt_val + 5999) % 6000;
        if (reset) begin
            m_mode      <= M_IDLE;
            m_up        <= 1'b1;
            m_clr       <= 1'b1;
            m_lap       <= 0;
            m_prev_zero <= 1'b1;
            for (int i = 0; i <= SYNC; i++) begin
                h_go[i]  <= 1'b0;
                h_lap[i] <= 1'b0;
                h_clr[i] <= 1'b0;
            end
        end else begin
            m_mode      <= n_mode;
            m_up        <= n_up;
            m_clr       <= n_clr;
            m_lap       <= n_lap;
            m_prev_zero <= (cnt_val == 0);
            h_go[0]  <= btn_go;
            h_lap[0] <= btn_lap;
            h_clr[0] <= btn_clr;
            for (int i = 1; i <= SYNC; i++) begin
                h_go[i]  <= h_go[i-1];
                h_lap[i] <= h_lap[i-1];
                h_clr[i] <= h_clr[i-1];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset   = 1'b1;
        btn_go  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        preset_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the one edge that sampled the button high
    task automatic pulse(input int which);
        if (which == 0) btn_go = 1'b1;
        else if (which == 1) btn_lap = 1'b1;
        else btn_clr = 1'b1;
        @(negedge clk);
        btn_go  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        int n = 0;
        while (cnt_val != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cnt_val != target) begin
            failures++;
            $display("FAIL %s: timeout, count=%0d wanted %0d", name, cnt_val, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({go, clr, up, alarm} !== 4'b0110) begin
            failures++;
            $display("FAIL reset_outputs: go/clr/up/alarm=%b expected 0110", {go, clr, up, alarm});
        end
        @(negedge clk);
        checks++;
        if (clr !== 1'b0) begin
            failures++;
            $display("FAIL reset_clr_one_cycle: clr=%b expected 0", clr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({go, clr, up, alarm} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_idle: go/clr/up/alarm=%b expected 0010", {go, clr, up, alarm});
        end
    endtask

    task automatic test_run_lap();
        do_reset();
        sw_up = 1'b1;
        repeat (2) @(negedge clk);
        pulse(0);
        checks++;
        if (go !== 1'b0) begin
            failures++;
            $display("FAIL go_latency_e1: go=%b expected 0", go);
        end
        @(negedge clk);
        checks++;
        if (go !== 1'b0) begin
            failures++;
            $display("FAIL go_latency_e2: go=%b expected 0", go);
        end
        @(negedge clk);
        checks++;
        if ({go, up} !== 2'b11) begin
            failures++;
            $display("FAIL go_latency_e3: go/up=%b expected 11", {go, up});
        end
        wait_cnt(121, 400, "wait_0_12_1");
        pulse(1);
        repeat (2) @(negedge clk);
        checks++;
        if (disp_all !== 16'h0123) begin
            failures++;
            $display("FAIL lap_snapshot: disp=%h expected 0123", disp_all);
        end
        wait_cnt(150, 100, "wait_0_15_0");
        checks++;
        if (disp_all !== 16'h0123 || go !== 1'b1) begin
            failures++;
            $display("FAIL lap_frozen: disp=%h go=%b expected 0123 go=1", disp_all, go);
        end
        pulse(1);
        repeat (2) @(negedge clk);
        checks++;
        if (disp_all !== digits(cnt_val)) begin
            failures++;
            $display("FAIL lap_release: disp=%h expected %h", disp_all, digits(cnt_val));
        end
    endtask

    task automatic test_pause_resume();
        bit saw_clr = 1'b0;
        pulse(0);
        repeat (2) @(negedge clk);
        checks++;
        if (go !== 1'b0) begin
            failures++;
            $display("FAIL pause_go: go=%b expected 0", go);
        end
        sw_up = 1'b0;
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({go, up} !== 2'b11) begin
            failures++;
            $display("FAIL resume_up_kept: go/up=%b expected 11", {go, up});
        end
        pulse(2);
        for (int i = 0; i < 5; i++) begin
            if (clr !== 1'b0 || go !== 1'b1) saw_clr = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_clr) begin
            failures++;
            $display("FAIL clr_ignored_in_run: clr/go disturbed=%b expected 0", saw_clr);
        end
    endtask

    task automatic test_countdown_done();
        do_reset();
        sw_up = 1'b0;
        repeat (2) @(negedge clk);
        preset_req = 1'b1;
        preset_val = 2;
        @(negedge clk);
        preset_req = 1'b0;
        pulse(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({go, up} !== 2'b10) begin
            failures++;
            $display("FAIL countdown_start: go/up=%b expected 10", {go, up});
        end
        wait_cnt(0, 10, "wait_zero");
        checks++;
        if (alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_early: alarm=%b expected 0", alarm);
        end
        @(negedge clk);
        checks++;
        if ({go, alarm} !== 2'b01) begin
            failures++;
            $display("FAIL done_entry: go/alarm=%b expected 01", {go, alarm});
        end
        pulse(2);
        @(negedge clk);
        checks++;
        if ({clr, alarm} !== 2'b01) begin
            failures++;
            $display("FAIL done_clr_latency: clr/alarm=%b expected 01", {clr, alarm});
        end
        @(negedge clk);
        checks++;
        if ({clr, alarm, go} !== 3'b100) begin
            failures++;
            $display("FAIL done_clr_pulse: clr/alarm/go=%b expected 100", {clr, alarm, go});
        end
        @(negedge clk);
        checks++;
        if (clr !== 1'b0) begin
            failures++;
            $display("FAIL clr_pulse_width: clr=%b expected 0", clr);
        end
    endtask

    task automatic test_wrap_timer();
        bit early = 1'b0;
        int n = 0;
        do_reset();
        sw_up = 1'b0;
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        wait_cnt(5999, 5, "wait_wrap");
        checks++;
        if (alarm !== 1'b0 || go !== 1'b1 || disp_all !== 16'h9599) begin
            failures++;
            $display("FAIL wrap_no_alarm: alarm=%b go=%b disp=%h expected 0 1 9599", alarm, go, disp_all);
        end
        while (cnt_val != 0 && n < 6100) begin
            if (alarm !== 1'b0) early = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (early || cnt_val != 0) begin
            failures++;
            $display("FAIL timer_run: early_alarm=%b count=%0d expected 0 0", early, cnt_val);
        end
        @(negedge clk);
        checks++;
        if (alarm !== 1'b1) begin
            failures++;
            $display("FAIL timer_done: alarm=%b expected 1", alarm);
        end
    endtask

    task automatic test_held_button();
        do_reset();
        sw_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_go = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL held_single_event: go=%b expected 1", go);
        end
        btn_go = 1'b0;
        repeat (3) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        checks++;
        if (go !== 1'b0) begin
            failures++;
            $display("FAIL held_rearm: go=%b expected 0", go);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sw_up = 1'b1;
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        btn_go  = 1'b1;
        btn_clr = 1'b1;
        @(negedge clk);
        btn_go  = 1'b0;
        btn_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (clr !== 1'b0) begin
            failures++;
            $display("FAIL prio_latency: clr=%b expected 0", clr);
        end
        @(negedge clk);
        checks++;
        if ({clr, go} !== 2'b10) begin
            failures++;
            $display("FAIL prio_clr_wins: clr/go=%b expected 10", {clr, go});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({clr, go} !== 2'b00) begin
            failures++;
            $display("FAIL prio_go_dropped: clr/go=%b expected 00", {clr, go});
        end
        pulse(0);
        repeat (2) @(negedge clk);
        repeat (5) @(negedge clk);
        pulse(1);
        repeat (2) @(negedge clk);
        checks++;
        if (disp_all !== exp_disp() || m_mode != M_LAP) begin
            failures++;
            $display("FAIL lap_before_reset: disp=%h expected %h", disp_all, exp_disp());
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({go, clr} !== 2'b01 || disp_all !== digits(cnt_val)) begin
            failures++;
            $display("FAIL reset_in_lap: go/clr=%b disp=%h expected 01 %h", {go, clr}, disp_all, digits(cnt_val));
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            checks++;
            if ({go, clr, up, alarm} !== {m_running, m_clr, m_up, (m_mode == M_DONE)}) begin
                failures++;
                $display("FAIL rand_ctrl @%0d: go/clr/up/alarm=%b expected %b", cyc,
                         {go, clr, up, alarm}, {m_running, m_clr, m_up, (m_mode == M_DONE)});
            end
            checks++;
            if (disp_all !== exp_disp()) begin
                failures++;
                $display("FAIL rand_disp @%0d: disp=%h expected %h", cyc, disp_all, exp_disp());
            end
            preset_req = 1'b0;
            if ($urandom_range(0, 15) == 0) btn_go = ~btn_go;
            if ($urandom_range(0, 11) == 0) btn_lap = ~btn_lap;
            if ($urandom_range(0, 40) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 30) == 0) sw_up = ~sw_up;
            if ($urandom_range(0, 150) == 0) begin
                preset_req = 1'b1;
                preset_val = $urandom_range(0, 6);
            end
            reset = ($urandom_range(0, 700) == 0);
        end
        reset = 1'b0;
        preset_req = 1'b0;
        btn_go = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_lap();
        test_pause_resume();
        test_countdown_done();
        test_wrap_timer();
        test_held_button();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
